apb_arbiter: RTL
================

Name: apb_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared peripheral bus (UART and other memory-mapped slaves).
- Accepts word requests from requester 0 (core load/store port) and requester 1 (debug/DMA port), grants one at a time round-robin, and drives the SETUP/ACCESS phases.
- Returns read data, error and a one-cycle done pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width.
- TIMEOUT_CYCLES, 16, ACCESS cycles before abort (only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request; held high until matching done
- req_addr  in  2*ADDR_WIDTH  per-requester address, slice i = requester i
- req_wdata  in  2*DATA_WIDTH  per-requester write data
- req_write  in  2  per-requester write flag
- req_stb  in  2*4  per-requester byte strobes
- req_done  out  2  one-cycle completion pulse per requester
- req_rdata  out  DATA_WIDTH  read data, valid with req_done
- req_err  out  1  error, valid with req_done
- paddr  out  ADDR_WIDTH  bus address
- pdata  out  DATA_WIDTH  bus write data
- pwrite  out  1  bus write
- pstb  out  4  bus strobes
- psel  out  1  bus select
- penable  out  1  bus enable
- prdata  in  DATA_WIDTH  slave read data
- ready  in  1  slave ready
- perr  in  1  slave error

Behaviour:
- Interface: one clock `pclk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer = requester 0 preferred.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE -> SETUP when any `req_valid` is set.
  - Grant the sole requester, or on a tie the requester indicated by the pointer.
  - Latch that requester's addr, wdata, write and stb into bus registers.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then -> ACCESS.
- ACCESS: `psel`=1, `penable`=1 until `ready`=1 is sampled.
  - On that edge: capture `prdata` and `perr`, drop `psel`/`penable`, go to RESP.
- RESP: one cycle, during which:
  - `req_done[granted]`=1, `req_rdata` = captured data, `req_err` = captured perr;
  - `penable`=0 so the slave's ready clears;
  - pointer moves to the other requester; next state IDLE.
- Latency: IDLE to done is 4 cycles minimum (SETUP, ACCESS with ready, RESP); each extra wait cycle adds 1.
- Back-to-back requests: requester must drop `req_valid` in the cycle after done, otherwise it is re-arbitrated.
  - The fairness pointer guarantees the other requester wins the next tie.
- Bus outputs hold stable from SETUP through ACCESS. `paddr` and `pdata` hold their last value in IDLE; only `psel`/`penable` return to 0.
- `req_rdata`/`req_err` are don't-care except when done is pulsed; drive them 0 outside RESP.
- A requester dropping `req_valid` mid-transfer has no effect; the transfer completes and done is still pulsed.
- Reset mid-transfer: next cycle `psel`=`penable`=0, no done pulse, pointer reset.
- `ready` sampled in SETUP or IDLE is ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: go to RESP with `req_err`=1 and `req_rdata`=0.
  - If `ready` arrives in the same cycle as the limit, the real response wins.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package `apb_pkg`:
  - enum `apb_state_t` {IDLE, SETUP, ACCESS, RESP};
  - localparam NUM_REQ=2;
  - localparam STB_WIDTH=4.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from `req_valid` plus pointer, with the pointer-update register.
- The FSM and bus registers stay in the top module.

Test Plan:
- Single write: req0 write addr 0x10000000, wdata 0x41, stb 0x1 -> SETUP with `psel`=1, `penable`=0; then ACCESS; slave ready next cycle -> `req_done`=01, `req_err`=0, 4 cycles total.
- Single read: req1 read 0x10000005, slave returns 0x61 with ready after 3 wait cycles -> `req_done`=10 and `req_rdata`=0x61 on cycle 7.
- Simultaneous requests: both raised and held for 4 transfers -> grants alternate 0,1,0,1; each requester sees its own done.
- Error propagation: slave returns `perr`=1 with ready -> `req_err`=1 for exactly the done cycle.
- Reset mid-ACCESS: assert `rst` during ACCESS -> `psel`/`penable` are 0 on the next edge, no done pulse, and requester 0 wins the next tie.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never readies -> done with `req_err`=1 and `req_rdata`=0 after 16 ACCESS cycles; with the macro undefined, still in ACCESS at cycle 100.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the peripheral-bus arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned STB_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer names the requester that wins a tie
// and moves to the other requester after each completed transfer.
module rr_arbiter2
    import apb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    input  logic               i_last_gnt,
    output logic               o_gnt_c,
    output logic               o_any_c
);

    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~i_last_gnt;
        end
    end

    always_comb begin
        o_any_c = |i_req;
        o_gnt_c = 1'b0;
        case (i_req)
            2'b10:   o_gnt_c = 1'b1;
            2'b11:   o_gnt_c = r_ptr;
            default: o_gnt_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester arbiter and SETUP/ACCESS sequencer for the peripheral bus.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without ready.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*STB_WIDTH-1:0]  req_stb,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pdata,
    output logic                          pwrite,
    output logic [STB_WIDTH-1:0]          pstb,
    output logic                          psel,
    output logic                          penable,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          ready,
    input  logic                          perr
);

    apb_state_t r_state;
    apb_state_t w_state_next;
    logic       r_gnt;
    logic       w_gnt;
    logic       w_any;
    logic       w_abort;

    rr_arbiter2 u_rr (
        .clk        (pclk),
        .rst        (rst),
        .i_req      (req_valid),
        .i_advance  (r_state == RESP),
        .i_last_gnt (r_gnt),
        .o_gnt_c    (w_gnt),
        .o_any_c    (w_any)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts ACCESS cycles without ready; cleared while in SETUP.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !ready) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_abort = (r_state == ACCESS) && !ready &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign w_abort      = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = SETUP;
            SETUP:   w_state_next = ACCESS;
            ACCESS:  if (ready || w_abort) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bus registers latch on grant and hold until the next grant.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_gnt  <= 1'b0;
            paddr  <= '0;
            pdata  <= '0;
            pwrite <= 1'b0;
            pstb   <= '0;
        end else if ((r_state == IDLE) && w_any) begin
            r_gnt  <= w_gnt;
            paddr  <= w_gnt ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : req_addr[0 +: ADDR_WIDTH];
            pdata  <= w_gnt ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
            pwrite <= w_gnt ? req_write[1] : req_write[0];
            pstb   <= w_gnt ? req_stb[STB_WIDTH +: STB_WIDTH]     : req_stb[0 +: STB_WIDTH];
        end
    end

    // Phase strobes and response outputs are registered from the next state;
    // a real ready takes precedence over a timeout in the same cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            req_done  <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
        end else begin
            psel      <= (w_state_next == SETUP) || (w_state_next == ACCESS);
            penable   <= (w_state_next == ACCESS);
            req_done  <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
            if (w_state_next == RESP) begin
                req_done <= r_gnt ? 2'b10 : 2'b01;
                if (ready) begin
                    req_rdata <= prdata;
                    req_err   <= perr;
                end else begin
                    req_err   <= 1'b1;
                end
            end
        end
    end

endmodule
